// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Playfield geometry defaults and buffer controller state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

   localparam int DEF_FIELD_W = 10;
   localparam int DEF_FIELD_H = 20;
   localparam int DEF_ROW_AW  = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_WAIT  = 2'd2,
      ST_COPY  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/field_bank.sv
`default_nettype none
// ============================================================================
// Module      : field_bank
// Description : FIELD_H x FIELD_W cell register array, one row write port,
//               one cell read and two combinational row reads.
// Revision    : 1.0 - initial release
// ============================================================================
module field_bank
   import tetris_pkg::*;
#(
   parameter int FIELD_W = DEF_FIELD_W,
   parameter int FIELD_H = DEF_FIELD_H,
   parameter int ROW_AW  = DEF_ROW_AW
) (
   input  logic               vga_clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [ROW_AW-1:0]  waddr,
   input  logic [FIELD_W-1:0] wdata,
   input  logic [7:0]         x,
   input  logic [7:0]         y,
   output logic               bit_out,
   input  logic [ROW_AW-1:0]  raddr_a,
   output logic [FIELD_W-1:0] rdata_a,
   input  logic [ROW_AW-1:0]  raddr_b,
   output logic [FIELD_W-1:0] rdata_b
);

   logic [FIELD_W-1:0] r_mem [FIELD_H];
   logic [FIELD_W-1:0] w_row_y;

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIELD_H; i++) r_mem[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < FIELD_H; i++) begin
            if (waddr == ROW_AW'(i)) r_mem[i] <= wdata;
         end
      end
   end

   // Decoded muxes: any index outside the array naturally yields zero.
   always_comb begin
      w_row_y = '0;
      rdata_a = '0;
      rdata_b = '0;
      for (int i = 0; i < FIELD_H; i++) begin
         if (y == 8'(i))          w_row_y = r_mem[i];
         if (raddr_a == ROW_AW'(i)) rdata_a = r_mem[i];
         if (raddr_b == ROW_AW'(i)) rdata_b = r_mem[i];
      end
   end

   always_comb begin
      bit_out = 1'b0;
      for (int j = 0; j < FIELD_W; j++) begin
         if (x == 8'(j)) bit_out = w_row_y[j];
      end
   end

endmodule
`default_nettype wire

// File: rtl/tetris_field_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tetris_field_buffer
// Description : Double-buffered Tetris playfield; back bank is published to
//               the display bank row-by-row at frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_field_buffer
   import tetris_pkg::*;
#(
   parameter int FIELD_W = DEF_FIELD_W,
   parameter int FIELD_H = DEF_FIELD_H,
   parameter int ROW_AW  = DEF_ROW_AW
) (
   input  logic               vga_clk,
   input  logic               rst_n,
   input  logic [7:0]         x_coord,
   input  logic [7:0]         y_coord,
   output logic               coord_value,
   input  logic               draw_finish,
   input  logic               wr_en,
   input  logic [ROW_AW-1:0]  wr_row,
   input  logic [FIELD_W-1:0] wr_data,
   output logic               wr_ready,
   input  logic [ROW_AW-1:0]  rd_row,
   output logic [FIELD_W-1:0] rd_data,
   input  logic               clr_req,
   input  logic               swap_req,
   output logic               swap_done
);

   state_t             r_state, w_state_nxt;
   logic [ROW_AW-1:0]  r_cnt, w_cnt_nxt;
   logic               r_swap_pend;
   logic               r_swap_done, w_swap_done_nxt;
   logic [FIELD_W-1:0] r_rd_data;
   logic               w_enter_copy;
   logic               w_last_row;
   logic               w_wr_fire;
   logic               w_xy_in_range;
   logic               w_front_bit;

   logic               w_back_we;
   logic [ROW_AW-1:0]  w_back_waddr;
   logic [FIELD_W-1:0] w_back_wdata;
   logic [FIELD_W-1:0] w_back_rd_row;
   logic [FIELD_W-1:0] w_back_copy_row;

   logic               w_unused_back_bit;
   logic [FIELD_W-1:0] w_unused_front_row_a;
   logic [FIELD_W-1:0] w_unused_front_row_b;

   assign w_last_row    = (r_cnt == ROW_AW'(FIELD_H - 1));
   assign wr_ready      = (r_state == ST_IDLE) || (r_state == ST_WAIT);
   assign w_wr_fire     = wr_en && wr_ready && (32'(wr_row) < FIELD_H);
   assign w_xy_in_range = (32'(x_coord) < FIELD_W) && (32'(y_coord) < FIELD_H);
   assign coord_value   = w_xy_in_range && w_front_bit;
   assign rd_data       = r_rd_data;
   assign swap_done     = r_swap_done;

   // CLEAR owns the back write port; game writes are locked out there anyway.
   assign w_back_we    = w_wr_fire || (r_state == ST_CLEAR);
   assign w_back_waddr = (r_state == ST_CLEAR) ? r_cnt : wr_row;
   assign w_back_wdata = (r_state == ST_CLEAR) ? '0 : wr_data;

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_swap_pend <= 1'b0;
         r_swap_done <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         // A request landing on the copy-entry cycle arms the next frame.
         r_swap_pend <= swap_req || (r_swap_pend && !w_enter_copy);
         r_swap_done <= w_swap_done_nxt;
         r_rd_data   <= (32'(rd_row) < FIELD_H) ? w_back_rd_row : '0;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_enter_copy    = 1'b0;
      w_swap_done_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (clr_req) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end else if (r_swap_pend) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_CLEAR: begin
            if (w_last_row) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_WAIT: begin
            if (draw_finish) begin
               w_state_nxt  = ST_COPY;
               w_cnt_nxt    = '0;
               w_enter_copy = 1'b1;
            end
         end
         ST_COPY: begin
            if (w_last_row) begin
               w_state_nxt     = ST_IDLE;
               w_cnt_nxt       = '0;
               w_swap_done_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   field_bank #(
      .FIELD_W (FIELD_W),
      .FIELD_H (FIELD_H),
      .ROW_AW  (ROW_AW)
   ) u_back (
      .vga_clk (vga_clk),
      .rst_n   (rst_n),
      .we      (w_back_we),
      .waddr   (w_back_waddr),
      .wdata   (w_back_wdata),
      .x       (8'd0),
      .y       (8'd0),
      .bit_out (w_unused_back_bit),
      .raddr_a (rd_row),
      .rdata_a (w_back_rd_row),
      .raddr_b (r_cnt),
      .rdata_b (w_back_copy_row)
   );

   field_bank #(
      .FIELD_W (FIELD_W),
      .FIELD_H (FIELD_H),
      .ROW_AW  (ROW_AW)
   ) u_front (
      .vga_clk (vga_clk),
      .rst_n   (rst_n),
      .we      (r_state == ST_COPY),
      .waddr   (r_cnt),
      .wdata   (w_back_copy_row),
      .x       (x_coord),
      .y       (y_coord),
      .bit_out (w_front_bit),
      .raddr_a ('0),
      .rdata_a (w_unused_front_row_a),
      .raddr_b ('0),
      .rdata_b (w_unused_front_row_b)
   );

endmodule
`default_nettype wire
